// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04 sensor stand-in: answers an accepted trig pulse with an echo whose width
// encodes the programmed distance, or a timeout-width echo when no valid target is set.
module ultrasonic_echo_emulator #(
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int US_PER_CM   = 58,
  parameter int MIN_TRIG_US = 10,
  parameter int BURST_US    = 200,
  parameter int MAX_CM      = 400,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 10000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  input  logic       target_present,
  output logic       echo,
  output logic       busy,
  output logic       short_trig,
  output logic       range_err,
  output logic [7:0] last_trig_us
);
  localparam int CLKS_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int PW          = $clog2(CLKS_PER_US);

  typedef enum logic [2:0] {S_IDLE, S_TRIG_HI, S_BURST, S_ECHO, S_HOLDOFF} state_t;

  state_t        state, state_next;
  logic          trig_s1, trig_s2, trig_d;
  logic [1:0]    sync_vld;
  logic          armed;
  logic          trig_rise, trig_fall;
  logic [PW-1:0] presc;
  logic          us_tick;
  logic [15:0]   us_cnt, us_cnt_inc, cnt_now;
  logic [7:0]    trig_us;
  logic [8:0]    dist_q;
  logic          tgt_q;
  logic          out_of_range;
  logic [15:0]   echo_us;
  logic          short_hit;

  // Synchroniser and edge detector. armed only rises once a genuine low has been
  // seen, so a trig already high when reset is released is never taken as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_s1  <= 1'b0;
      trig_s2  <= 1'b0;
      trig_d   <= 1'b0;
      sync_vld <= '0;
      armed    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      trig_s1  <= trig;
      trig_s2  <= trig_s1;
      trig_d   <= trig_s2;
      sync_vld <= {sync_vld[0], 1'b1};
      armed    <= armed | (sync_vld[1] & ~trig_s2);
    end
  end

  assign trig_rise = trig_s2 & ~trig_d & armed;
  assign trig_fall = ~trig_s2 & trig_d;

  assign us_tick    = (presc == PW'(CLKS_PER_US - 1));
  assign us_cnt_inc = (us_cnt == 16'hFFFF) ? us_cnt : us_cnt + 16'd1;
  assign cnt_now    = us_tick ? us_cnt_inc : us_cnt;
  assign trig_us    = (cnt_now > 16'd255) ? 8'hFF : cnt_now[7:0];

  assign out_of_range = !tgt_q || (dist_q == 9'd0) || (dist_q > 9'(MAX_CM));
  assign echo_us      = out_of_range ? 16'(TIMEOUT_US) : 16'(dist_q) * 16'(US_PER_CM);

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_next = state;
    short_hit  = 1'b0;
    case (state)
      S_IDLE:    if (trig_rise) state_next = S_TRIG_HI;
      S_TRIG_HI: if (trig_fall) begin
                   if (trig_us >= 8'(MIN_TRIG_US)) begin
                     state_next = S_BURST;
                   end else begin
                     state_next = S_IDLE;
                     short_hit  = 1'b1;
                   end
                 end
      S_BURST:   if (us_tick && us_cnt == 16'(BURST_US - 1)) state_next = S_ECHO;
      S_ECHO:    if (us_tick && us_cnt == echo_us - 16'd1) state_next = S_HOLDOFF;
      S_HOLDOFF: if (us_tick && us_cnt == 16'(HOLDOFF_US - 1)) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Timebase restarts on every state change so a state of N us lasts N*CLKS_PER_US clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      presc  <= '0;
      us_cnt <= '0;
      dist_q <= '0;
      tgt_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        presc  <= '0;
        us_cnt <= '0;
      end else begin
        presc  <= us_tick ? '0 : presc + PW'(1);
        us_cnt <= us_tick ? us_cnt_inc : us_cnt;
      end
      if (state == S_TRIG_HI && state_next == S_BURST) begin
        dist_q <= distance_cm;
        tgt_q  <= target_present;
      end
    end
  end

  // Outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo         <= 1'b0;
      busy         <= 1'b0;
      short_trig   <= 1'b0;
      range_err    <= 1'b0;
      last_trig_us <= '0;
    end else begin
      echo       <= (state_next == S_ECHO);
      busy       <= (state_next == S_BURST) || (state_next == S_ECHO) ||
                    (state_next == S_HOLDOFF);
      short_trig <= short_hit;
      range_err  <= (state == S_BURST) && (state_next == S_ECHO) && out_of_range;
      if (state == S_TRIG_HI && trig_fall) last_trig_us <= trig_us;
    end
  end
endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Self-checking bench: timestamp model of the sensor checked every cycle, plus
// hand-computed literal expectations for widths, latencies and counts.
module tb_ultrasonic_echo_emulator;
  localparam int K        = 4;     // clk per us at 4 MHz
  localparam int UPC      = 2;
  localparam int MIN_US   = 10;
  localparam int BURST    = 20;
  localparam int MAXCM    = 400;
  localparam int TMO      = 1000;
  localparam int HOLD     = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       trig = 1'b0;
  logic [8:0] distance_cm = 9'd100;
  logic       target_present = 1'b1;
  logic       echo, busy, short_trig, range_err;
  logic [7:0] last_trig_us;

  int n_checks = 0;
  int n_fail   = 0;

  ultrasonic_echo_emulator #(
    .CLK_FREQ_HZ(K * 1_000_000), .US_PER_CM(UPC), .MIN_TRIG_US(MIN_US), .BURST_US(BURST),
    .MAX_CM(MAXCM), .TIMEOUT_US(TMO), .HOLDOFF_US(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trig(trig), .distance_cm(distance_cm),
    .target_present(target_present), .echo(echo), .busy(busy), .short_trig(short_trig),
    .range_err(range_err), .last_trig_us(last_trig_us)
  );

  initial forever #5 clk = ~clk;

  // ---------------- model state (cycle timestamps) ----------------
  longint cyc = 0;
  longint t_rise, t_acc, t_short, e_rise, e_fall, t_idle;
  int     mode;            // 0 idle, 1 trig high, 2 answering
  int     m_last;
  bit     m_oor;
  bit     h1, h2, h3;      // pin samples from 1, 2, 3 edges ago
  int     n_smp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mode = 0; m_last = 0; m_oor = 1'b0;
    t_rise = -1; t_acc = -1; t_short = -1; e_rise = -1; e_fall = -1; t_idle = -1;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0; n_smp = 0;
  endtask

  // The sensor reacts to a pin edge three edges after the edge that first samples it.
  task automatic model_step();
    bit     rise, fall;
    longint w;
    int     d, wid;
    rise = (n_smp >= 3) && h2 && !h3;
    fall = (n_smp >= 3) && !h2 && h3;
    if (mode == 2 && t_idle < cyc) mode = 0;
    if (mode == 0) begin
      if (rise) begin mode = 1; t_rise = cyc; end
    end else if (mode == 1 && fall) begin
      w = (cyc - t_rise) / K;
      if (w > 255) w = 255;
      m_last = int'(w);
      if (m_last >= MIN_US) begin
        d      = int'(distance_cm);
        m_oor  = !target_present || d == 0 || d > MAXCM;
        wid    = m_oor ? TMO : d * UPC;
        t_acc  = cyc;
        e_rise = cyc + BURST * K;
        e_fall = e_rise + wid * K;
        t_idle = e_fall + HOLD * K;
        mode   = 2;
      end else begin
        t_short = cyc;
        mode    = 0;
      end
    end
    h3 = h2; h2 = h1; h1 = trig; n_smp++;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_clear();
      else begin
        cyc++;
        model_step();
      end
    end
  end

  // ---------------- per-cycle compare plus echo monitor ----------------
  longint rise_cyc = 0;
  int     width = 0, n_echo = 0, n_rerr = 0, n_short = 0, n_busy = 0;
  bit     echo_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    check("echo",       32'(echo),         32'((cyc >= e_rise) && (cyc < e_fall)));
    check("busy",       32'(busy),         32'((cyc >= t_acc) && (cyc < t_idle)));
    check("range_err",  32'(range_err),    32'(m_oor && cyc == e_rise));
    check("short_trig", 32'(short_trig),   32'(cyc == t_short));
    check("last_trig",  32'(last_trig_us), 32'(m_last));
    if (!reset_n) echo_prev = 1'b0;
    else begin
      if (echo && !echo_prev) begin n_echo++; rise_cyc = cyc; end
      if (!echo && echo_prev) width = int'(cyc - rise_cyc);
      if (range_err)  n_rerr++;
      if (short_trig) n_short++;
      if (busy)       n_busy++;
      echo_prev = echo;
    end
  end

  // ---------------- stimulus ----------------
  task automatic trig_hold(input int us);
    trig = 1'b1;
    repeat (us * K) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic trig_pulse(input int us, output longint fall_at);
    trig_hold(us);
    fall_at = cyc;
  endtask

  task automatic wait_until(input longint c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (4) @(negedge clk);
    while (busy && n < 20000) begin @(negedge clk); n++; end
    check({name, "_idle"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  int     d_tab[3]  = '{401, 0, 50};
  bit     tp_tab[3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    longint f, f2;
    int e0, r0, s0, b0;
    #1 reset_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_echo", 32'(echo), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_last", 32'(last_trig_us), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: nominal 100 cm
    e0 = n_echo; r0 = n_rerr; b0 = n_busy;
    trig_pulse(12, f);
    repeat (4) @(negedge clk);
    check("s1_last", 32'(last_trig_us), 12);
    wait_idle("s1");
    check("s1_count",   32'(n_echo - e0), 1);
    check("s1_latency", 32'(rise_cyc - f), 83);
    check("s1_width",   32'(width), 800);
    check("s1_rerr",    32'(n_rerr - r0), 0);
    check("s1_busy",    32'(n_busy - b0), 1280);

    // 2: short trig, boundary 9/10 us, saturating width
    e0 = n_echo; s0 = n_short; b0 = n_busy;
    trig_pulse(5, f);
    repeat (10) @(negedge clk);
    check("s2_short", 32'(n_short - s0), 1);
    check("s2_last",  32'(last_trig_us), 5);
    trig_pulse(9, f);
    repeat (10) @(negedge clk);
    check("s2_short9", 32'(n_short - s0), 2);
    check("s2_echo0",  32'(n_echo - e0), 0);
    check("s2_busy0",  32'(n_busy - b0), 0);
    distance_cm = 9'd1;
    trig_pulse(10, f);
    wait_idle("s2_min");
    check("s2_last10", 32'(last_trig_us), 10);
    check("s2_width1", 32'(width), 8);
    trig_pulse(300, f);
    wait_idle("s2_sat");
    check("s2_last_sat", 32'(last_trig_us), 255);
    check("s2_short_end", 32'(n_short - s0), 2);

    // 3: out-of-range targets
    for (int i = 0; i < 3; i++) begin
      r0 = n_rerr;
      distance_cm    = 9'(d_tab[i]);
      target_present = tp_tab[i];
      trig_pulse(12, f);
      wait_idle("s3");
      check("s3_width", 32'(width), 4000);
      check("s3_rerr",  32'(n_rerr - r0), 1);
    end
    target_present = 1'b1;

    // 4: largest valid distance; input change during BURST is ignored
    r0 = n_rerr;
    distance_cm = 9'd400;
    trig_pulse(12, f);
    repeat (30) @(negedge clk);
    distance_cm = 9'd10;
    wait_idle("s4");
    check("s4_width", 32'(width), 3200);
    check("s4_rerr",  32'(n_rerr - r0), 0);

    // 5: retriggers during ECHO and HOLDOFF, trig held across HOLDOFF end
    e0 = n_echo; s0 = n_short;
    distance_cm = 9'd100;
    trig_pulse(15, f);
    wait_until(f + 200);
    trig_hold(12);
    wait_until(f + 950);
    trig_hold(12);
    wait_until(f + 1100);
    trig = 1'b1;
    wait_until(f + 1400);
    trig = 1'b0;
    repeat (20) @(negedge clk);
    check("s5_count", 32'(n_echo - e0), 1);
    check("s5_width", 32'(width), 800);
    check("s5_last",  32'(last_trig_us), 15);
    check("s5_short", 32'(n_short - s0), 0);
    trig_pulse(11, f2);
    wait_idle("s5_new");
    check("s5_count2",  32'(n_echo - e0), 2);
    check("s5_last2",   32'(last_trig_us), 11);
    check("s5_latency", 32'(rise_cyc - f2), 83);

    // 6: reset in the middle of an echo, trig high across reset release
    e0 = n_echo;
    trig_pulse(12, f);
    wait_until(f + 83 + 400);
    @(posedge clk);
    #2 reset_n = 1'b0;
    trig = 1'b1;
    #1;
    check("s6_echo_async", 32'(echo), 0);
    check("s6_busy",       32'(busy), 0);
    check("s6_last",       32'(last_trig_us), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    trig = 1'b0;
    repeat (20) @(negedge clk);
    check("s6_no_accept", 32'(n_echo - e0), 1);
    trig_pulse(12, f);
    wait_idle("s6");
    check("s6_count",   32'(n_echo - e0), 2);
    check("s6_width",   32'(width), 800);
    check("s6_latency", 32'(rise_cyc - f), 83);
    check("s6_last12",  32'(last_trig_us), 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ultrasonic_echo_emulator.md
Name: ultrasonic_echo_emulator

Overview:
- Sensor-side counterpart of the HC-SR04 ranging controller. It accepts the controller's trig pulse and answers with an echo pulse whose width encodes a programmed distance (distance_cm * US_PER_CM microseconds).
- Out-of-range targets produce a timeout-width echo.
- Used as a hardware-in-the-loop stand-in for the physical sensor on the FPGA board and as the bench model for controller verification.

Parameters:
- CLK_FREQ_HZ, 125_000_000, system clock frequency. CLKS_PER_US = CLK_FREQ_HZ/1_000_000, must be an integer ≥2.
- US_PER_CM, 58, echo microseconds per centimetre.
- MIN_TRIG_US, 10, minimum trig high width accepted.
- BURST_US, 200, delay from accepted trig fall to echo rise (emulated 40 kHz burst).
- MAX_CM, 400, largest distance reported as a valid echo.
- TIMEOUT_US, 38000, echo width for no target or out of range.
- HOLDOFF_US, 10000, dead time after echo fall during which trig is ignored.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- trig  input  1  trigger from controller, asynchronous, synchronised internally
- distance_cm  input  9  programmed target distance, sampled at trig acceptance
- target_present  input  1  1 = target in view; sampled with distance_cm
- echo  output  1  echo pulse to controller
- busy  output  1  high in BURST, ECHO, HOLDOFF
- short_trig  output  1  1-clk pulse when a trig shorter than MIN_TRIG_US is rejected
- range_err  output  1  1-clk pulse when a timeout-width echo starts
- last_trig_us  output  8  width in µs of last completed trig pulse, saturating at 255

Behaviour:
- Reset (async, reset_n=0):
  - echo=0, busy=0, short_trig=0, range_err=0, last_trig_us=0.
  - FSM goes to IDLE; counters and synchroniser flops clear.
  - Reset mid-echo drops echo immediately.
- trig passes a 2-flop synchroniser plus a registered edge detector. Pin-to-edge-detect latency is 3 clk.
- Timebase: a prescaler counts 0..CLKS_PER_US-1 and produces a 1-clk us_tick. The prescaler and the µs counter both clear on every state entry, so a state lasting N µs lasts exactly N*CLKS_PER_US clk.
- FSM states: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
- IDLE:
  - Synchronised trig rising edge → TRIG_HI.
  - A trig already high when leaving reset is not accepted until it has gone low and risen again.
- TRIG_HI: counts µs while synchronised trig is high; the 8-bit count saturates at 255. On the falling edge, last_trig_us is loaded with the count, then:
  - If count ≥ MIN_TRIG_US: latch distance_cm and target_present, go to BURST.
  - Otherwise: pulse short_trig and return to IDLE.
- BURST: after BURST_US µs → ECHO, driving echo=1 in the same cycle the state changes.
- ECHO:
  - Width W: if latched target_present=0, or distance=0, or distance>MAX_CM, then W=TIMEOUT_US and range_err pulses on ECHO entry. Otherwise W = distance*US_PER_CM.
  - W is computed in a 16-bit unsigned; max 400*58 = 23200 < 38000 fits.
  - echo stays high exactly W*CLKS_PER_US clk, then goes low → HOLDOFF.
- HOLDOFF: echo=0 for HOLDOFF_US µs → IDLE.
- Trig edges in BURST/ECHO/HOLDOFF are ignored: no state change, no short_trig, last_trig_us unchanged.
- Trig already high at the end of HOLDOFF is not accepted; a fresh rising edge is required.
- Changes on distance_cm or target_present after acceptance have no effect on the echo in progress.
- busy is registered and equals (state ∈ {BURST, ECHO, HOLDOFF}).
- echo is registered and glitch-free.
- Resulting end-to-end latency: trig pin fall → echo rise = 3 + BURST_US*CLKS_PER_US clk.

Test Plan (CLK_FREQ_HZ=10_000_000, HOLDOFF_US=100 unless noted):
1. Nominal: distance_cm=100, target_present=1, trig high 12 µs.
   - last_trig_us=12.
   - echo rises 3+2000 clk after trig fall, high exactly 58000 clk, busy spans BURST..HOLDOFF, range_err=0.
2. Short trig: trig high 5 µs.
   - short_trig pulses once, last_trig_us=5, echo stays 0, busy stays 0.
3. Out of range, three runs: distance_cm=401; distance_cm=0; target_present=0 with distance_cm=50.
   - Each gives range_err pulse at echo rise and echo high 380000 clk.
4. Boundary: distance_cm=400 → echo high 232000 clk, no range_err.
   - Same run: change distance_cm to 10 during BURST → width unchanged.
5. Retrigger: trig pulses of 12 µs during ECHO and during HOLDOFF.
   - Both ignored, echo width unchanged, last_trig_us unchanged.
   - Trig held high across HOLDOFF end is not accepted.
   - Next clean trig after IDLE produces a new echo.
6. Reset mid-echo: assert reset_n=0 halfway through the echo of scenario 1.
   - echo=0 asynchronously, all outputs at reset values.
   - After release, a 12 µs trig yields a correct full echo.
